// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA serial engines (TX and RX).
package acia_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } acia_state_t;

    localparam int DATA_BITS = 8;

    // pclk pulses per serial symbol; integer division, truncating.
    function automatic int acia_div(input int clk_freq, input int sym_rate);
        return clk_freq / sym_rate;
    endfunction

endpackage

// File: rtl/acia_baud_tick.sv
// Symbol timer: counts pclk pulses and emits a one-clk tick on the last
// pulse of a symbol. A symbol is DIV pulses, or DIV*STOP_BITS when the
// long period is selected (used for the whole stop interval).
module acia_baud_tick #(
    parameter int DIV       = 28,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pclk,
    input  logic clr,
    input  logic long_sel,
    output logic tick
);

    localparam int CW = $clog2(DIV * STOP_BITS);
    localparam logic [CW-1:0] LAST_SHORT = CW'(DIV - 1);
    localparam logic [CW-1:0] LAST_LONG  = CW'(DIV * STOP_BITS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    assign last = long_sel ? LAST_LONG : LAST_SHORT;
    // Combinational so the FSM acts on the same pclk pulse that ends the symbol.
    assign tick = pclk && (cnt == last);

    // Pulse counter; clear has priority and also holds the count at 0 while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (pclk) begin
            cnt <= (cnt == last) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/acia_tx.sv
// 8N1/8N2 serial transmitter with a single-byte holding register so that
// back-to-back writes produce frames with no idle gap on the line.
module acia_tx
    import acia_pkg::*;
#(
    parameter int clk_freq  = 3333333,
    parameter int sym_rate  = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pclk,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_serial
);

    localparam int DIV = acia_div(clk_freq, sym_rate);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("acia_tx: clk_freq/sym_rate must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("acia_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    acia_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q,   bit_d;
    logic [7:0]  hold_q,  hold_d;
    logic        hvld_q,  hvld_d;
    logic        ser_q,   ser_d;
    logic        busy_q,  busy_d;
    logic        load;
    logic        tick;
    logic        baud_clr;

    // Holding register is empty exactly when a write can be taken.
    assign tx_rdy    = !hvld_q;
    assign tx_busy   = busy_q;
    assign tx_serial = ser_q;

    // Counter is parked at 0 while idle and restarted with every start bit.
    assign baud_clr = load || (state_q == ST_IDLE);

    acia_baud_tick #(
        .DIV       (DIV),
        .STOP_BITS (STOP_BITS)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .pclk     (pclk),
        .clr      (baud_clr),
        .long_sel (state_q == ST_STOP),
        .tick     (tick)
    );

    // State register; reset drives the line high immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            hvld_q  <= 1'b0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            hvld_q  <= hvld_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: host write into the holding register, then the frame sequencer.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        hvld_d  = hvld_q;
        ser_d   = ser_q;
        busy_d  = busy_q;
        load    = 1'b0;

        // A write is taken only when the holding register is empty, so it
        // can never collide with a shifter load (which needs it full).
        if (tx_stb && !hvld_q) begin
            hold_d = tx_dat;
            hvld_d = 1'b1;
        end

        if (pclk) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hvld_q) load = 1'b1;
                end
                ST_START: begin
                    if (tick) begin
                        ser_d   = shift_q[0];
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_q == 3'd7) begin
                            ser_d   = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            shift_d = shift_q >> 1;
                            ser_d   = shift_q[1];
                            bit_d   = bit_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (hvld_q) begin
                            load = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Shifter load: start bit goes out on this very pulse.
        if (load) begin
            shift_d = hold_q;
            hvld_d  = 1'b0;
            ser_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_START;
        end
    end

endmodule

// File: tb/tb_acia_tx.sv
// Directed bench for acia_tx: table of single-byte writes at each pclk phase,
// plus hand-written back-to-back, overrun, 2-stop-bit and mid-frame-reset runs.
module tb_acia_tx;

    typedef struct {
        logic [7:0] dat;   // byte written
        int         ph;    // pclk phase counter value seen on the accept edge
        int         lat;   // clk edges from accept to start-bit fall
        logic [7:0] exp;   // byte expected on the line
    } vec_t;

    localparam int BIT_CLK = 84;   // 28 pclk pulses * 3 clk

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pclk;
    logic       tx_stb = 1'b0;
    logic [7:0] tx_dat = 8'h00;
    logic       sel = 1'b0;
    logic       stb_a, stb_b;
    logic       rdy_a, busy_a, ser_a;
    logic       rdy_b, busy_b, ser_b;
    logic       line, rdy, busy;
    logic [1:0] pc = 2'd0;
    int         cyc = 0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rx_b[$];
    int         rx_f[$];
    bit         rx_ok[$];

    vec_t vt[6];

    always #5 clk = ~clk;

    // pclk is high on every third clk edge.
    always @(posedge clk) begin
        pc  <= (pc == 2'd2) ? 2'd0 : pc + 2'd1;
        cyc <= cyc + 1;
    end
    assign pclk = (pc == 2'd2);

    assign stb_a = tx_stb & ~sel;
    assign stb_b = tx_stb & sel;
    assign line  = sel ? ser_b  : ser_a;
    assign rdy   = sel ? rdy_b  : rdy_a;
    assign busy  = sel ? busy_b : busy_a;

    acia_tx #(.clk_freq(3333333), .sym_rate(115200), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .pclk(pclk), .tx_dat(tx_dat), .tx_stb(stb_a),
        .tx_rdy(rdy_a), .tx_busy(busy_a), .tx_serial(ser_a)
    );

    acia_tx #(.clk_freq(3333333), .sym_rate(115200), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .pclk(pclk), .tx_dat(tx_dat), .tx_stb(stb_b),
        .tx_rdy(rdy_b), .tx_busy(busy_b), .tx_serial(ser_b)
    );

    // Line receiver: mid-bit sampling from the start-bit fall edge.
    int         m_f;
    logic [7:0] m_b;
    bit         m_ok;
    always begin
        @(negedge clk);
        if (reset_n && line == 1'b0) begin
            m_f  = cyc;
            m_ok = 1'b1;
            m_b  = 8'h00;
            repeat (BIT_CLK / 2) @(negedge clk);
            if (line != 1'b0) m_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLK) @(negedge clk);
                m_b[i] = line;
            end
            repeat (BIT_CLK) @(negedge clk);
            if (line != 1'b1) m_ok = 1'b0;
            rx_b.push_back(m_b);
            rx_f.push_back(m_f);
            rx_ok.push_back(m_ok);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Strobe one byte; ph<0 means any phase. acc = edge number that samples it.
    task automatic write_byte(input logic [7:0] d, input int ph, output int acc);
        @(negedge clk);
        if (ph >= 0) while (int'(pc) != ph) @(negedge clk);
        tx_dat = d;
        tx_stb = 1'b1;
        acc    = cyc + 1;
        @(negedge clk);
        tx_stb = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string nm);
        int k = 0;
        while (rx_b.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " frame arrival"}, int'(rx_b.size() >= n), 1);
    endtask

    task automatic pop_frame(input string nm, input logic [7:0] exp, output int f);
        logic [7:0] b;
        bit ok;
        f = 0;
        if (rx_b.size() != 0) begin
            b  = rx_b.pop_front();
            f  = rx_f.pop_front();
            ok = rx_ok.pop_front();
            chk({nm, " byte"}, int'(b), int'(exp));
            chk({nm, " framing"}, int'(ok), 1);
        end
    endtask

    task automatic wait_busy_low(output int t);
        int k = 0;
        while (busy != 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        t = (busy == 1'b0) ? cyc : -1;
    endtask

    task automatic wait_rdy(input string nm);
        int k = 0;
        while (rdy != 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " tx_rdy returns"}, int'(rdy), 1);
    endtask

    initial begin
        int acc, f1, f2, t, lows;

        vt[0] = '{8'hA5, 0, 2, 8'hA5};
        vt[1] = '{8'h3C, 1, 1, 8'h3C};
        vt[2] = '{8'hC3, 2, 3, 8'hC3};
        vt[3] = '{8'h00, 0, 2, 8'h00};
        vt[4] = '{8'hFF, 1, 1, 8'hFF};
        vt[5] = '{8'h81, 2, 3, 8'h81};

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ser_a", int'(ser_a), 1);
        chk("reset rdy_a", int'(rdy_a), 1);
        chk("reset busy_a", int'(busy_a), 0);
        chk("reset ser_b", int'(ser_b), 1);
        chk("reset rdy_b", int'(rdy_b), 1);
        chk("reset busy_b", int'(busy_b), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single bytes at each pclk phase
        for (int i = 0; i < 6; i++) begin
            write_byte(vt[i].dat, vt[i].ph, acc);
            chk($sformatf("vec%0d rdy low after write", i), int'(rdy), 0);
            wait_frames(1, $sformatf("vec%0d", i));
            pop_frame($sformatf("vec%0d", i), vt[i].exp, f1);
            chk($sformatf("vec%0d start latency", i), f1 - acc, vt[i].lat);
            wait_busy_low(t);
            chk($sformatf("vec%0d busy duration", i), t - f1, 10 * BIT_CLK);
        end

        // Back-to-back: no gap between frames
        write_byte(8'h55, -1, acc);
        wait_rdy("b2b");
        write_byte(8'h0F, -1, acc);
        wait_frames(2, "b2b");
        pop_frame("b2b first", 8'h55, f1);
        pop_frame("b2b second", 8'h0F, f2);
        chk("b2b frame spacing", f2 - f1, 10 * BIT_CLK);
        wait_busy_low(t);
        chk("b2b total busy", t - f1, 20 * BIT_CLK);

        // Overrun: third write while holding register full is dropped
        write_byte(8'h11, -1, acc);
        wait_rdy("ovr");
        write_byte(8'h22, -1, acc);
        chk("ovr rdy low before 3rd write", int'(rdy), 0);
        write_byte(8'h33, -1, acc);
        wait_frames(2, "ovr");
        pop_frame("ovr first", 8'h11, f1);
        pop_frame("ovr second", 8'h22, f2);
        wait_busy_low(t);
        repeat (900) @(negedge clk);
        chk("ovr no third frame", rx_b.size(), 0);

        // Two stop bits
        sel = 1'b1;
        repeat (2) @(negedge clk);
        write_byte(8'hFF, -1, acc);
        wait_rdy("stop2");
        write_byte(8'h5A, -1, acc);
        wait_frames(2, "stop2");
        pop_frame("stop2 first", 8'hFF, f1);
        pop_frame("stop2 second", 8'h5A, f2);
        chk("stop2 frame spacing", f2 - f1, 11 * BIT_CLK);
        wait_busy_low(t);
        chk("stop2 busy duration", t - f2, 11 * BIT_CLK);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-frame reset during data bit 3 of 8'h00
        write_byte(8'h00, -1, acc);
        begin
            int k = 0;
            while (ser_a != 1'b0 && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        f1 = cyc;
        while (cyc < f1 + 4 * BIT_CLK + 20) @(negedge clk);
        chk("rst line low in bit3", int'(ser_a), 0);
        chk("rst busy before", int'(busy_a), 1);
        reset_n = 1'b0;
        #1;
        chk("rst async line high", int'(ser_a), 1);
        chk("rst rdy", int'(rdy_a), 1);
        chk("rst busy", int'(busy_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ser_a != 1'b1) lows++;
        end
        chk("rst line idle after release", lows, 0);
        chk("rst busy idle after release", int'(busy_a), 0);
        rx_b.delete();
        rx_f.delete();
        rx_ok.delete();
        write_byte(8'h96, -1, acc);
        wait_frames(1, "post-rst");
        pop_frame("post-rst", 8'h96, f1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
